// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR transaction sequencer: state encoding,
// descriptor byte layout and the bus-mode code that means HDR-DDR.
package hdr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        RUN_CCC = 3'd3,
        RUN_DDR = 3'd4,
        RESTART = 3'd5,
        EXIT    = 3'd6,
        DONE    = 3'd7
    } seq_state_t;

    // Descriptor byte: [7] CP, [6] TOC, [5:4] reserved, [3:0] TID
    localparam int DESC_CP_BIT  = 7;
    localparam int DESC_TOC_BIT = 6;
    localparam int DESC_TID_MSB = 3;

    localparam logic [2:0] HDR_MODE_DDR = 3'd6;

endpackage

// File: rtl/hdr_seq_timer.sv
// Run-state watchdog for the HDR sequencer; only built with HDR_SEQ_TIMEOUT_EN.
// Counts cycles while i_run is high and flags the last permitted cycle.
`ifdef HDR_SEQ_TIMEOUT_EN
module hdr_seq_timer #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd1023
) (
    input  logic i_sys_clk,
    input  logic i_sys_rst_n,
    input  logic i_run,
    output logic o_expired
);

    logic [15:0] count_q;

    // Held at zero outside a run state, so every run entry starts from zero.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            count_q <= 16'd0;
        end else if (!i_run) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_q + 16'd1;
        end
    end

    assign o_expired = i_run && (count_q == TIMEOUT_CYC - 16'd1);

endmodule
`endif

// File: rtl/hdr_txn_sequencer.sv
// HDR-DDR descriptor sequencer: fetches descriptors, runs CCC or DDR blocks,
// issues restart/exit patterns. Optional run watchdog via HDR_SEQ_TIMEOUT_EN.
module hdr_txn_sequencer
    import hdr_pkg::*;
#(
    parameter logic [7:0]  DESC_BASE_ADDR = 8'd16,
    parameter logic [2:0]  HDR_DDR_MODE   = HDR_MODE_DDR,
    parameter logic [15:0] TIMEOUT_CYC    = 16'd1023
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst_n,
    input  logic       i_seq_en,
    input  logic [2:0] i_mode,
    input  logic [3:0] i_desc_cnt,
    output logic       o_regf_rd_en,
    output logic [7:0] o_regf_addr,
    input  logic [7:0] i_regf_data,
    output logic       o_ccc_en,
    input  logic       i_ccc_done,
    output logic       o_ddrmode_en,
    input  logic       i_ddr_mode_done,
    output logic [3:0] o_tid,
    output logic       o_restart_req,
    output logic       o_exit_req,
    input  logic       i_exit_done,
    output logic       o_done,
    output logic       o_err
);

    seq_state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] tid_d;
    logic       toc_q, toc_d;
    logic       err_d;
    logic       timeout;
    logic       mode_bad;
    logic       last_desc;
    logic [1:0] unused_rsvd;

    assign unused_rsvd = i_regf_data[5:4];
    assign mode_bad    = (i_mode != HDR_DDR_MODE);
    assign last_desc   = toc_q || (idx_q == i_desc_cnt - 4'd1);

`ifdef HDR_SEQ_TIMEOUT_EN
    logic in_run;
    assign in_run = (state_q == RUN_CCC) || (state_q == RUN_DDR);

    hdr_seq_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_sys_clk   (i_sys_clk),
        .i_sys_rst_n (i_sys_rst_n),
        .i_run       (in_run),
        .o_expired   (timeout)
    );
`else
    logic [15:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tid_d   = o_tid;
        toc_d   = toc_q;
        err_d   = o_err;
        // An abort outranks every other event in the same cycle.
        if (!i_seq_en && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_seq_en) begin
                        if (mode_bad) begin
                            err_d   = 1'b1;
                            state_d = EXIT;
                        end else if (i_desc_cnt == 4'd0) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = 4'd0;
                            err_d   = 1'b0;
                            state_d = FETCH;
                        end
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    tid_d   = i_regf_data[DESC_TID_MSB:0];
                    toc_d   = i_regf_data[DESC_TOC_BIT];
                    state_d = i_regf_data[DESC_CP_BIT] ? RUN_CCC : RUN_DDR;
                end
                RUN_CCC, RUN_DDR: begin
                    if (mode_bad || timeout) begin
                        err_d   = 1'b1;
                        state_d = EXIT;
                    end else if ((state_q == RUN_CCC) ? i_ccc_done : i_ddr_mode_done) begin
                        state_d = last_desc ? EXIT : RESTART;
                    end
                end
                RESTART: begin
                    idx_d   = idx_q + 4'd1;
                    state_d = FETCH;
                end
                EXIT: begin
                    if (i_exit_done) begin
                        state_d = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so each is high exactly
    // for the cycles spent in its state.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q       <= IDLE;
            idx_q         <= 4'd0;
            toc_q         <= 1'b0;
            o_tid         <= 4'd0;
            o_err         <= 1'b0;
            o_regf_rd_en  <= 1'b0;
            o_regf_addr   <= DESC_BASE_ADDR;
            o_ccc_en      <= 1'b0;
            o_ddrmode_en  <= 1'b0;
            o_restart_req <= 1'b0;
            o_exit_req    <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            toc_q         <= toc_d;
            o_tid         <= tid_d;
            o_err         <= err_d;
            o_regf_rd_en  <= (state_d == FETCH);
            o_regf_addr   <= DESC_BASE_ADDR + {4'd0, idx_d};
            o_ccc_en      <= (state_d == RUN_CCC);
            o_ddrmode_en  <= (state_d == RUN_DDR);
            o_restart_req <= (state_d == RESTART);
            o_exit_req    <= (state_d == EXIT);
            o_done        <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_hdr_txn_sequencer.sv
// Directed + scoreboard bench for hdr_txn_sequencer. Build with
// HDR_SEQ_TIMEOUT_EN defined to include the watchdog scenario.
module tb_hdr_txn_sequencer;
    import hdr_pkg::*;

    localparam logic [7:0] BASE = 8'hFE;  // exercises address wrap past 0xFF
`ifdef HDR_SEQ_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd8;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'd1023;
`endif
    localparam logic [3:0] K_FETCH = 4'd1, K_CCC = 4'd2, K_DDR = 4'd3,
                           K_RST = 4'd4, K_EXIT = 4'd5, K_DONE = 4'd6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seq_en, ccc_done, ddr_done, exit_done;
    logic [2:0] mode;
    logic [3:0] desc_cnt;
    logic       regf_rd_en, ccc_en, ddrmode_en, restart_req, exit_req, done, err;
    logic [7:0] regf_addr, regf_data;
    logic [3:0] tid;

    logic [7:0]  mem [256];
    logic [11:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hdr_txn_sequencer #(
        .DESC_BASE_ADDR (BASE),
        .HDR_DDR_MODE   (3'd6),
        .TIMEOUT_CYC    (TB_TIMEOUT)
    ) dut (
        .i_sys_clk       (clk),
        .i_sys_rst_n     (rst_n),
        .i_seq_en        (seq_en),
        .i_mode          (mode),
        .i_desc_cnt      (desc_cnt),
        .o_regf_rd_en    (regf_rd_en),
        .o_regf_addr     (regf_addr),
        .i_regf_data     (regf_data),
        .o_ccc_en        (ccc_en),
        .i_ccc_done      (ccc_done),
        .o_ddrmode_en    (ddrmode_en),
        .i_ddr_mode_done (ddr_done),
        .o_tid           (tid),
        .o_restart_req   (restart_req),
        .o_exit_req      (exit_req),
        .i_exit_done     (exit_done),
        .o_done          (done),
        .o_err           (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input logic [11:0] ev);
        logic [11:0] e;
        e = (exp_q.size() == 0) ? 12'hFFF : exp_q.pop_front();
        chk("event", {4'd0, ev}, {4'd0, e});
    endtask

    // Register-file model and output event monitor
    initial begin
        logic       pend;
        logic [7:0] pend_addr;
        logic       prev_ccc, prev_ddr, prev_exit;
        pend = 1'b0; pend_addr = 8'd0;
        prev_ccc = 1'b0; prev_ddr = 1'b0; prev_exit = 1'b0;
        regf_data = 8'h30;
        forever begin
            tick();
            regf_data = pend ? mem[pend_addr] : 8'h30;
            pend      = regf_rd_en;
            pend_addr = regf_addr;
            chk("both_en", {15'd0, ccc_en & ddrmode_en}, 16'd0);
            if (regf_rd_en)              post({K_FETCH, regf_addr});
            if (ccc_en && !prev_ccc)     post({K_CCC, 4'd0, tid});
            if (ddrmode_en && !prev_ddr) post({K_DDR, 4'd0, tid});
            if (restart_req)             post({K_RST, 8'd0});
            if (exit_req && !prev_exit)  post({K_EXIT, 8'd0});
            if (done)                    post({K_DONE, 7'd0, err});
            prev_ccc = ccc_en; prev_ddr = ddrmode_en; prev_exit = exit_req;
        end
    end

    // Answers run and exit states until o_done; also injects stray done pulses.
    task automatic serve(input bit answer, output int run_len);
        int  rc, xc;
        bit  seen;
        rc = 0; xc = 0; seen = 1'b0; run_len = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            tick();
            ccc_done = 1'b0; ddr_done = 1'b0; exit_done = 1'b0;
            if (done) begin
                seen   = 1'b1;
                seq_en = 1'b0;
            end else begin
                if (ccc_en || ddrmode_en) begin
                    rc++;
                    if (rc > run_len) run_len = rc;
                    if (rc == 1) begin
                        if (ccc_en) ddr_done = 1'b1; else ccc_done = 1'b1;
                    end
                    if (rc == 3 && answer) begin
                        if (ccc_en) ccc_done = 1'b1; else ddr_done = 1'b1;
                    end
                end else begin
                    rc = 0;
                end
                if (exit_req) begin
                    xc++;
                    if (xc == 1) begin ccc_done = 1'b1; ddr_done = 1'b1; end
                    if (xc == 3) exit_done = 1'b1;
                end else begin
                    xc = 0;
                end
            end
        end
        chk("done_seen", {15'd0, seen}, 16'd1);
        if (seen) begin
            tick();
            chk("done_width", {15'd0, done}, 16'd0);
        end
    endtask

    task automatic wait_run();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            tick();
            seen = ccc_en | ddrmode_en;
        end
        chk("run_reached", {15'd0, seen}, 16'd1);
    endtask

    task automatic q_empty(input string tag);
        chk(tag, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        int          len;
        int          cnt;
        logic [7:0]  d;
        logic [7:0]  a;
        for (int i = 0; i < 256; i++) mem[i] = 8'h30;
        rst_n = 1'b0; seq_en = 1'b0; mode = 3'd6; desc_cnt = 4'd0;
        ccc_done = 1'b0; ddr_done = 1'b0; exit_done = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_state", {13'd0, dut.state_q}, {13'd0, IDLE});
        chk("rst_addr", {8'd0, regf_addr}, {8'd0, BASE});
        chk("rst_outs", {9'd0, regf_rd_en, ccc_en, ddrmode_en, restart_req, exit_req, done, err},
            16'd0);
        chk("rst_tid", {12'd0, tid}, 16'd0);
        rst_n = 1'b1;
        tick();

        // Two descriptors: CCC then DDR with TOC, addresses wrap FE -> FF
        mem[8'hFE] = 8'h81; mem[8'hFF] = 8'h42; desc_cnt = 4'd2;
        exp_q.push_back({K_FETCH, 8'hFE}); exp_q.push_back({K_CCC, 8'h01});
        exp_q.push_back({K_RST, 8'h00});   exp_q.push_back({K_FETCH, 8'hFF});
        exp_q.push_back({K_DDR, 8'h02});   exp_q.push_back({K_EXIT, 8'h00});
        exp_q.push_back({K_DONE, 8'h00});
        seq_en = 1'b1;
        serve(1'b1, len);
        q_empty("a_q_empty");

        // TOC on the first descriptor: later descriptors never fetched
        mem[8'hFE] = 8'hC5; mem[8'hFF] = 8'h81; mem[8'h00] = 8'h82; desc_cnt = 4'd3;
        exp_q.push_back({K_FETCH, 8'hFE}); exp_q.push_back({K_CCC, 8'h05});
        exp_q.push_back({K_EXIT, 8'h00});  exp_q.push_back({K_DONE, 8'h00});
        seq_en = 1'b1;
        serve(1'b1, len);
        q_empty("b_q_empty");

        // Zero descriptors: straight to DONE
        desc_cnt = 4'd0;
        exp_q.push_back({K_DONE, 8'h00});
        seq_en = 1'b1;
        serve(1'b1, len);
        q_empty("c_q_empty");

        // Mode leaves HDR-DDR during RUN_CCC
        mem[8'hFE] = 8'h87; desc_cnt = 4'd1;
        exp_q.push_back({K_FETCH, 8'hFE}); exp_q.push_back({K_CCC, 8'h07});
        exp_q.push_back({K_EXIT, 8'h00});  exp_q.push_back({K_DONE, 8'h01});
        seq_en = 1'b1;
        wait_run();
        tick();
        mode = 3'd3;
        tick();
        chk("e_ccc_drop", {15'd0, ccc_en}, 16'd0);
        chk("e_err_set", {15'd0, err}, 16'd1);
        chk("e_exit_req", {15'd0, exit_req}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("e_exit_hold", {15'd0, exit_req}, 16'd1);
        end
        exit_done = 1'b1;
        tick();
        chk("e_done", {15'd0, done}, 16'd1);
        chk("e_exit_drop", {15'd0, exit_req}, 16'd0);
        exit_done = 1'b0; seq_en = 1'b0; mode = 3'd6;
        tick();
        chk("e_done_width", {15'd0, done}, 16'd0);
        chk("e_err_sticky", {15'd0, err}, 16'd1);
        q_empty("e_q_empty");

        // Abort in RUN_DDR coincident with the DDR done pulse
        mem[8'hFE] = 8'h03; desc_cnt = 4'd2;
        exp_q.push_back({K_FETCH, 8'hFE}); exp_q.push_back({K_DDR, 8'h03});
        seq_en = 1'b1;
        tick();
        chk("d_err_clear", {15'd0, err}, 16'd0);
        wait_run();
        tick();
        ddr_done = 1'b1; seq_en = 1'b0;
        tick();
        ddr_done = 1'b0;
        chk("d_state", {13'd0, dut.state_q}, {13'd0, IDLE});
        chk("d_outs", {12'd0, ddrmode_en, exit_req, restart_req, done}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("d_quiet", {14'd0, done, exit_req}, 16'd0);
        end
        q_empty("d_q_empty");

        // Wrong mode at start: error, exit, done
        mode = 3'd5; desc_cnt = 4'd2;
        exp_q.push_back({K_EXIT, 8'h00}); exp_q.push_back({K_DONE, 8'h01});
        seq_en = 1'b1;
        serve(1'b1, len);
        mode = 3'd6;
        q_empty("g_q_empty");

        // Random descriptor lists
        for (int r = 0; r < 3; r++) begin
            cnt = $urandom_range(1, 4);
            desc_cnt = 4'(cnt);
            for (int i = 0; i < cnt; i++) begin
                d = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 2'b00,
                     4'($urandom_range(0, 15))};
                a = BASE + 8'(i);
                mem[a] = d;
                exp_q.push_back({K_FETCH, a});
                exp_q.push_back({(d[7] ? K_CCC : K_DDR), 4'd0, d[3:0]});
                if (d[6] || i == cnt - 1) begin
                    exp_q.push_back({K_EXIT, 8'h00});
                    break;
                end
                exp_q.push_back({K_RST, 8'h00});
            end
            exp_q.push_back({K_DONE, 8'h00});
            seq_en = 1'b1;
            serve(1'b1, len);
            q_empty("r_q_empty");
        end

`ifdef HDR_SEQ_TIMEOUT_EN
        // Watchdog: DDR run with no done pulse
        mem[8'hFE] = 8'h09; desc_cnt = 4'd1;
        exp_q.push_back({K_FETCH, 8'hFE}); exp_q.push_back({K_DDR, 8'h09});
        exp_q.push_back({K_EXIT, 8'h00});  exp_q.push_back({K_DONE, 8'h01});
        seq_en = 1'b1;
        serve(1'b0, len);
        chk("t_run_len", 16'(len), 16'd8);
        q_empty("t_q_empty");
`endif

        // Reset in the middle of a CCC run
        mem[8'hFE] = 8'h81; mem[8'hFF] = 8'h42; desc_cnt = 4'd2;
        exp_q.push_back({K_FETCH, 8'hFE}); exp_q.push_back({K_CCC, 8'h01});
        seq_en = 1'b1;
        wait_run();
        #2 rst_n = 1'b0;
        #1;
        chk("m_state", {13'd0, dut.state_q}, {13'd0, IDLE});
        chk("m_outs", {9'd0, regf_rd_en, ccc_en, ddrmode_en, restart_req, exit_req, done, err},
            16'd0);
        chk("m_addr", {8'd0, regf_addr}, {8'd0, BASE});
        seq_en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        q_empty("m_q_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
